// File: rtl/adpcm_pkg.sv
// Shared widths, constants and table functions for the ADPCM adaptation-speed control.
package adpcm_pkg;

    localparam int DMS_W = 12;
    localparam int DML_W = 14;
    localparam int AP_W  = 10;
    localparam int AL_W  = 7;
    localparam int Y_W   = 13;

    localparam logic [AP_W-1:0] AP_TRIG = 10'd256;
    localparam logic [Y_W-1:0]  Y_THR   = 13'd1536;

    // FUNCTF: magnitude of the codeword mapped to the short-term rate weight FI.
    function automatic logic [2:0] functf(input logic [3:0] code);
        logic [2:0] im;
        logic [2:0] fi;
        im = code[3] ? ~code[2:0] : code[2:0];
        case (im)
            3'd0, 3'd1, 3'd2: fi = 3'd0;
            3'd3, 3'd4, 3'd5: fi = 3'd1;
            3'd6:             fi = 3'd3;
            default:          fi = 3'd7;
        endcase
        return fi;
    endfunction

    function automatic logic [AL_W-1:0] lima(input logic [AP_W-1:0] ap);
        logic [AL_W-1:0] al;
        if (ap >= AP_TRIG) al = AL_W'(64);
        else               al = ap[8:2];
        return al;
    endfunction

endpackage

// File: rtl/adpcm_speed_filt.sv
// Combinational per-sample filters: FILTA/FILTB on the read state (stage 1) and
// SUBTB/FILTC/TRIGA on the stage-2 operands. The two paths are independent.
module adpcm_speed_filt
    import adpcm_pkg::*;
(
    input  logic [3:0]       i_code,
    input  logic [DMS_W-1:0] i_dms,
    input  logic [DML_W-1:0] i_dml,
    output logic [DMS_W-1:0] o_dms_n,
    output logic [DML_W-1:0] o_dml_n,
    input  logic [DMS_W-1:0] i_s2_dms,
    input  logic [DML_W-1:0] i_s2_dml,
    input  logic [AP_W-1:0]  i_ap,
    input  logic [Y_W-1:0]   i_y,
    input  logic             i_tdp,
    input  logic             i_tr,
    output logic [AP_W-1:0]  o_ap_n
);

    logic [2:0]         w_fi;
    logic signed [15:0] w_a_diff;
    logic signed [15:0] w_a_step;
    logic signed [15:0] w_b_diff;
    logic signed [15:0] w_b_step;
    logic signed [15:0] w_sub;
    logic [15:0]        w_difm;
    logic [15:0]        w_dthr;
    logic               w_ax;
    logic signed [11:0] w_c_diff;
    logic signed [11:0] w_c_step;
    logic [AP_W-1:0]    w_app;

    always_comb begin
        w_fi     = functf(i_code);
        // Differences are formed 16 bits wide so the floor shift never loses the sign.
        w_a_diff = $signed({4'd0, w_fi, 9'd0}) - $signed({4'd0, i_dms});
        w_a_step = w_a_diff >>> 5;
        o_dms_n  = DMS_W'(i_dms + w_a_step);
        w_b_diff = $signed({2'd0, w_fi, 11'd0}) - $signed({2'd0, i_dml});
        w_b_step = w_b_diff >>> 7;
        o_dml_n  = DML_W'(i_dml + w_b_step);

        w_sub    = $signed({2'd0, i_s2_dms, 2'b00}) - $signed({2'd0, i_s2_dml});
        w_difm   = w_sub[15] ? 16'(-w_sub) : 16'(w_sub);
        w_dthr   = {5'd0, i_s2_dml[DML_W-1:3]};
        w_ax     = !((i_y >= Y_THR) && (w_difm < w_dthr) && !i_tdp);
        w_c_diff = $signed({2'd0, w_ax, 9'd0}) - $signed({2'd0, i_ap});
        w_c_step = w_c_diff >>> 4;
        w_app    = AP_W'(i_ap + w_c_step);
        o_ap_n   = i_tr ? AP_TRIG : w_app;
    end

endmodule

// File: rtl/adpcm_speed_ctl.sv
// Per-channel adaptation-speed state (DMS/DML/AP) with a two-stage update pipeline,
// same-channel forwarding, channel clear and a registered AL read port.
module adpcm_speed_ctl
    import adpcm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_valid,
    input  logic [CH_W-1:0] clr_ch,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [CH_W-1:0] upd_ch,
    input  logic [3:0]      upd_i,
    input  logic [Y_W-1:0]  upd_y,
    input  logic            upd_tdp,
    input  logic            upd_tr,
    output logic            done_valid,
    output logic [CH_W-1:0] done_ch,
    input  logic [CH_W-1:0] al_rd_ch,
    output logic [AL_W-1:0] al
);

    logic [DMS_W-1:0] r_dms [CHANNELS];
    logic [DML_W-1:0] r_dml [CHANNELS];
    logic [AP_W-1:0]  r_ap  [CHANNELS];

    logic             r_s2_valid;
    logic [CH_W-1:0]  r_s2_ch;
    logic [DMS_W-1:0] r_s2_dms;
    logic [DML_W-1:0] r_s2_dml;
    logic [AP_W-1:0]  r_s2_ap;
    logic [Y_W-1:0]   r_s2_y;
    logic             r_s2_tdp;
    logic             r_s2_tr;
    logic [AL_W-1:0]  r_al;

    logic             w_accept;
    logic             w_fwd_hit;
    logic [DMS_W-1:0] w_rd_dms;
    logic [DML_W-1:0] w_rd_dml;
    logic [AP_W-1:0]  w_rd_ap;
    logic [DMS_W-1:0] w_dms_n;
    logic [DML_W-1:0] w_dml_n;
    logic [AP_W-1:0]  w_ap_n;
    logic [AP_W-1:0]  w_al_ap;
    logic             w_s2_kill;

    assign upd_ready  = !reset && !clr_valid;
    assign w_accept   = upd_valid && upd_ready;
    assign done_valid = r_s2_valid && !reset;
    assign done_ch    = r_s2_ch;
    assign al         = r_al;
    assign w_s2_kill  = clr_valid && (clr_ch == r_s2_ch);

    // Stage 1 sees the stage-2 result when both stages hold the same channel.
    always_comb begin
        w_fwd_hit = r_s2_valid && (r_s2_ch == upd_ch);
        w_rd_dms  = w_fwd_hit ? r_s2_dms : r_dms[upd_ch];
        w_rd_dml  = w_fwd_hit ? r_s2_dml : r_dml[upd_ch];
        w_rd_ap   = w_fwd_hit ? w_ap_n   : r_ap[upd_ch];
    end

    // AL reflects the state as it stands after this edge, including clears.
    always_comb begin
        w_al_ap = r_ap[al_rd_ch];
        if (clr_valid && (clr_ch == al_rd_ch)) begin
            w_al_ap = '0;
        end else if (r_s2_valid && (r_s2_ch == al_rd_ch)) begin
            w_al_ap = w_ap_n;
        end
    end

    adpcm_speed_filt u_filt (
        .i_code   (upd_i),
        .i_dms    (w_rd_dms),
        .i_dml    (w_rd_dml),
        .o_dms_n  (w_dms_n),
        .o_dml_n  (w_dml_n),
        .i_s2_dms (r_s2_dms),
        .i_s2_dml (r_s2_dml),
        .i_ap     (r_s2_ap),
        .i_y      (r_s2_y),
        .i_tdp    (r_s2_tdp),
        .i_tr     (r_s2_tr),
        .o_ap_n   (w_ap_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_al       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_dms[c] <= '0;
                r_dml[c] <= '0;
                r_ap[c]  <= '0;
            end
        end else begin
            r_s2_valid <= w_accept;
            r_al       <= lima(w_al_ap);
            if (r_s2_valid && !w_s2_kill) begin
                r_dms[r_s2_ch] <= r_s2_dms;
                r_dml[r_s2_ch] <= r_s2_dml;
                r_ap[r_s2_ch]  <= w_ap_n;
            end
            if (clr_valid) begin
                r_dms[clr_ch] <= '0;
                r_dml[clr_ch] <= '0;
                r_ap[clr_ch]  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s2_ch  <= upd_ch;
            r_s2_dms <= w_dms_n;
            r_s2_dml <= w_dml_n;
            r_s2_ap  <= w_rd_ap;
            r_s2_y   <= upd_y;
            r_s2_tdp <= upd_tdp;
            r_s2_tr  <= upd_tr;
        end
    end

endmodule
